fabric_ccff_loader: RTL and testbench

// - Drives the configuration-chain protocol from the initiator end. Accepts bitstream words from a host,

---
 rtl/fabric_ccff_loader_pkg.sv | 17 +
 rtl/fabric_ccff_loader_crc.sv | 29 ++
 rtl/fabric_ccff_loader.sv | 159 +++++++++++++++
 tb/tb_fabric_ccff_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_ccff_loader_pkg.sv
// Shared types and constants for the ccff chain loader.
package fabric_ccff_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2
    } ccff_state_e;

    localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
    localparam logic [15:0] CCFF_CRC_INIT = 16'hFFFF;

    function automatic int unsigned ccff_cnt_w(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/fabric_ccff_loader_crc.sv
// Bit-serial CRC-16 CCITT accumulator, MSB-first update, no final XOR.
module ccff_crc16_serial
    import fabric_ccff_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic        w_fb;
    logic [15:0] r_crc;

    assign w_fb  = r_crc[15] ^ i_bit;
    assign o_crc = r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CCFF_CRC_INIT;
        end else if (i_clr) begin
            r_crc <= CCFF_CRC_INIT;
        end else if (i_en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CCFF_CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/fabric_ccff_loader.sv
// Loads a host bitstream into a ccff chain, then recirculates it once and
// compares the read-back CRC against the written CRC.
module fabric_ccff_loader
    import fabric_ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8
)(
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int CNT_W = ccff_cnt_w(CHAIN_LEN);
    localparam int IDX_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);

    ccff_state_e       r_state;
    ccff_state_e       w_next;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [WORD_W-1:0] r_sreg;
    logic              r_done;
    logic              w_start;
    logic              w_load_shift;
    logic              w_ver_shift;
    logic              w_to_verify;
    logic              w_ver_done;
    logic              w_cnt_full;
    logic              w_accept;
    logic [15:0]       w_wr_crc;
    logic [15:0]       w_rd_crc;

    assign w_cnt_full = (r_bit_cnt == LEN_C);
    assign w_accept   = cfg_valid & cfg_ready;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        w_load_shift  = 1'b0;
        w_ver_shift   = 1'b0;
        w_to_verify   = 1'b0;
        w_ver_done    = 1'b0;
        cfg_ready     = 1'b0;
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_next  = LOAD;
                    w_start = 1'b1;
                end
            end
            LOAD: begin
                // Refill while the last bit is still going out, so words stream without a bubble.
                cfg_ready = !w_cnt_full &&
                            ((r_bit_idx == '0) ||
                             ((r_bit_idx == IDX_W'(1)) && (r_bit_cnt < LAST_C)));
                if (w_cnt_full) begin
                    w_next      = VERIFY;
                    w_to_verify = 1'b1;
                end else if (r_bit_idx != '0) begin
                    w_load_shift  = 1'b1;
                    ccff_shift_en = 1'b1;
                    ccff_head     = r_sreg[0];
                end
            end
            VERIFY: begin
                w_ver_shift   = 1'b1;
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                if (r_bit_cnt == LAST_C) begin
                    w_next     = IDLE;
                    w_ver_done = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
        if (cfg_abort) begin
            w_next     = IDLE;
            w_start    = 1'b0;
            w_ver_done = 1'b0;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_sreg    <= '0;
            r_done    <= 1'b0;
        end else begin
            if (cfg_abort || w_start) begin
                r_done <= 1'b0;
            end else if (w_ver_done) begin
                r_done <= 1'b1;
            end

            if (w_start || w_to_verify) begin
                r_bit_cnt <= '0;
            end else if (w_load_shift || w_ver_shift) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            if (w_start) begin
                r_bit_idx <= '0;
            end else if (w_accept) begin
                r_sreg    <= cfg_data;
                r_bit_idx <= IDX_W'(WORD_W);
            end else if (w_load_shift) begin
                r_sreg    <= r_sreg >> 1;
                r_bit_idx <= r_bit_idx - IDX_W'(1);
            end
        end
    end

    ccff_crc16_serial u_wr_crc (
        .clk   (prog_clk),
        .rst_n (prog_reset_n),
        .i_clr (w_start),
        .i_en  (w_load_shift),
        .i_bit (r_sreg[0]),
        .o_crc (w_wr_crc)
    );

    ccff_crc16_serial u_rd_crc (
        .clk   (prog_clk),
        .rst_n (prog_reset_n),
        .i_clr (w_start),
        .i_en  (w_ver_shift),
        .i_bit (ccff_tail),
        .o_crc (w_rd_crc)
    );

    // Both CRCs freeze in IDLE until the next start, so the compare stays valid while done is held.
    assign crc_err = r_done & (w_rd_crc != w_wr_crc);
    assign done    = r_done;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_fabric_ccff_loader.sv
// Bench for fabric_ccff_loader: chain models, bit-queue/CRC reference and directed scenarios.
module tb_fabric_ccff_loader;

    localparam int LA = 32;
    localparam int LB = 20;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_start = 1'b0, a_abort = 1'b0, a_valid = 1'b0;
    logic [W-1:0] a_data = '0;
    logic         a_ready, a_head, a_sen, a_tail, a_busy, a_done, a_err;
    logic         b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0;
    logic [W-1:0] b_data = '0;
    logic         b_ready, b_head, b_sen, b_tail, b_busy, b_done, b_err;

    fabric_ccff_loader #(.CHAIN_LEN(LA), .WORD_W(W)) u_dut_a (
        .prog_clk(clk), .prog_reset_n(rst_n), .cfg_start(a_start), .cfg_abort(a_abort),
        .cfg_data(a_data), .cfg_valid(a_valid), .cfg_ready(a_ready), .ccff_head(a_head),
        .ccff_shift_en(a_sen), .ccff_tail(a_tail), .busy(a_busy), .done(a_done), .crc_err(a_err)
    );

    fabric_ccff_loader #(.CHAIN_LEN(LB), .WORD_W(W)) u_dut_b (
        .prog_clk(clk), .prog_reset_n(rst_n), .cfg_start(b_start), .cfg_abort(b_abort),
        .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready), .ccff_head(b_head),
        .ccff_shift_en(b_sen), .ccff_tail(b_tail), .busy(b_busy), .done(b_done), .crc_err(b_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] crc16(input logic [127:0] v, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            if (c[15] ^ v[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Reference model: chains, written-bit list, read-back-bit list, shift/stall counts.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [LA-1:0] a_chain = '0, a_wv = '0, a_rv = '0;
    int a_wn = 0, a_nsh = 0, a_stall = 0, a_acc_cyc = 0;
    logic a_fault = 1'b0;
    assign a_tail = a_chain[0];

    always @(posedge clk) begin
        if (a_start && !a_abort && !a_busy && rst_n) begin
            a_wn <= 0; a_nsh <= 0; a_stall <= 0;
        end else begin
            if (a_valid && a_ready) begin
                for (int j = 0; j < W; j++) if (a_wn + j < LA) a_wv[a_wn + j] <= a_data[j];
                a_wn <= (a_wn + W < LA) ? a_wn + W : LA;
                if (a_wn == 0) a_acc_cyc <= cyc;
            end
            if (a_busy && !a_sen && a_nsh > 0 && a_nsh < LA) a_stall <= a_stall + 1;
        end
        if (a_sen) begin
            a_chain <= {a_head, a_chain[LA-1:1]};
            if (a_nsh >= LA && a_nsh < 2 * LA) a_rv[a_nsh - LA] <= a_tail;
            a_nsh <= a_nsh + 1;
        end else if (a_fault && a_busy && a_nsh == LA) begin
            a_chain[7] <= ~a_chain[7];
        end
    end

    logic [LB-1:0] b_chain = '0, b_wv = '0, b_rv = '0;
    int b_wn = 0, b_nsh = 0;
    assign b_tail = b_chain[0];

    always @(posedge clk) begin
        if (b_start && !b_abort && !b_busy && rst_n) begin
            b_wn <= 0; b_nsh <= 0;
        end else if (b_valid && b_ready) begin
            for (int j = 0; j < W; j++) if (b_wn + j < LB) b_wv[b_wn + j] <= b_data[j];
            b_wn <= (b_wn + W < LB) ? b_wn + W : LB;
        end
        if (b_sen) begin
            b_chain <= {b_head, b_chain[LB-1:1]};
            if (b_nsh >= LB && b_nsh < 2 * LB) b_rv[b_nsh - LB] <= b_tail;
            b_nsh <= b_nsh + 1;
        end
    end

    // Per-cycle compare against the model.
    logic a_done_q = 1'b0, b_done_q = 1'b0;
    always @(negedge clk) begin
        if (a_sen) begin
            chk("a_busy_on_shift", a_busy, 1'b1);
            if (a_nsh < LA) chk("a_head_load", a_head, a_wv[a_nsh]);
            else            chk("a_head_recirc", a_head, a_tail);
        end
        if (!a_busy) chk("a_idle_quiet", {a_sen, a_ready, a_head}, 3'b000);
        if (a_done && !a_done_q) begin
            chk("a_done_shifts", a_nsh, 2 * LA);
            chk("a_crc_err_model", a_err, crc16(a_wv, LA) != crc16(a_rv, LA));
        end
        a_done_q <= a_done;

        if (b_sen) begin
            chk("b_busy_on_shift", b_busy, 1'b1);
            if (b_nsh < LB) chk("b_head_load", b_head, b_wv[b_nsh]);
            else            chk("b_head_recirc", b_head, b_tail);
        end
        if (!b_busy) chk("b_idle_quiet", {b_sen, b_ready, b_head}, 3'b000);
        if (b_done && !b_done_q) begin
            chk("b_done_shifts", b_nsh, 2 * LB);
            chk("b_crc_err_model", b_err, crc16(b_wv, LB) != crc16(b_rv, LB));
        end
        b_done_q <= b_done;
    end

    task automatic pulse_start_a();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
    endtask

    task automatic send_a(input logic [W-1:0] d);
        int t = 0;
        a_data = d; a_valid = 1'b1;
        while (!a_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("a_ready_timeout", a_ready, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [W-1:0] d);
        int t = 0;
        b_data = d; b_valid = 1'b1;
        while (!b_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("b_ready_timeout", b_ready, 1'b1);
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic load_a(input logic [31:0] words, input int stall);
        pulse_start_a();
        for (int i = 0; i < 4; i++) begin
            if (i == 2 && stall > 0) begin
                int t = 0;
                while (!a_ready && t < 100) begin @(negedge clk); t++; end
                repeat (stall) @(negedge clk);
            end
            send_a(words[8*i +: 8]);
        end
    endtask

    task automatic wait_done_a();
        int t = 0;
        while (!a_done && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) chk("a_done_timeout", a_done, 1'b1);
    endtask

    task automatic wait_done_b();
        int t = 0;
        while (!b_done && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) chk("b_done_timeout", b_done, 1'b1);
    endtask

    task automatic wait_nsh_a(input int n);
        int t = 0;
        while (a_nsh != n && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) chk("a_nsh_timeout", a_nsh, n);
    endtask

    task automatic quiet_a(input string name);
        chk(name, {a_ready, a_head, a_sen, a_busy, a_done, a_err}, 6'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] sv;
        string        s;
        byte          ch;
        int           k;

        // Model pins: single bits and the CCITT check string "123456789".
        sv = '0;
        chk("pin_crc_bit1", crc16(128'h1, 1), 16'hFFFE);
        chk("pin_crc_bit0", crc16(sv, 1), 16'hEFDF);
        s = "123456789";
        k = 0;
        for (int i = 0; i < 9; i++) begin
            ch = s[i];
            for (int j = 7; j >= 0; j--) begin sv[k] = ch[j]; k++; end
        end
        chk("pin_crc_check", crc16(sv, 72), 16'h29B1);

        repeat (3) @(negedge clk);
        quiet_a("reset_a_outputs");
        chk("reset_b_outputs", {b_ready, b_head, b_sen, b_busy, b_done, b_err}, 6'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: back-to-back load of 4 words.
        load_a(32'h01FF3CA5, 0);
        wait_done_a();
        chk("t1_done", a_done, 1'b1);
        chk("t1_crc_err", a_err, 1'b0);
        chk("t1_busy", a_busy, 1'b0);
        chk("t1_chain", a_chain, 32'h01FF3CA5);
        chk("t1_latency", cyc - a_acc_cyc, 66);
        chk("t1_no_stall", a_stall, 0);

        // T2: 20-bit chain, third word overshoots.
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        send_b(8'hA5);
        send_b(8'h3C);
        send_b(8'hF7);
        chk("t2_ready_drop", b_ready, 1'b0);
        wait_done_b();
        chk("t2_done", b_done, 1'b1);
        chk("t2_crc_err", b_err, 1'b0);
        chk("t2_chain", b_chain, 20'h73CA5);

        // T3: 5-cycle host stall between words 2 and 3.
        @(negedge clk);
        load_a(32'h01FF3CA5, 5);
        wait_done_a();
        chk("t3_stall", a_stall, 5);
        chk("t3_latency", cyc - a_acc_cyc, 71);
        chk("t3_chain", a_chain, 32'h01FF3CA5);
        chk("t3_done", a_done, 1'b1);
        chk("t3_crc_err", a_err, 1'b0);

        // T4: bit 7 of the chain corrupted between LOAD and VERIFY.
        a_fault = 1'b1;
        @(negedge clk);
        load_a(32'h01FF3CA5, 0);
        wait_done_a();
        a_fault = 1'b0;
        chk("t4_done", a_done, 1'b1);
        chk("t4_crc_err", a_err, 1'b1);
        chk("t4_chain", a_chain, 32'h01FF3C25);
        pulse_start_a();
        chk("t4_restart_done", a_done, 1'b0);
        chk("t4_restart_err", a_err, 1'b0);
        chk("t4_restart_busy", a_busy, 1'b1);
        a_abort = 1'b1;
        @(negedge clk); a_abort = 1'b0;
        chk("t4_abort_busy", a_busy, 1'b0);

        // T5: abort while bit 13 is being shifted, then a clean full load.
        pulse_start_a();
        send_a(8'hA5);
        send_a(8'h3C);
        wait_nsh_a(13);
        chk("t5_shifting", a_sen, 1'b1);
        a_abort = 1'b1;
        @(negedge clk); a_abort = 1'b0;
        chk("t5_busy", a_busy, 1'b0);
        chk("t5_done", a_done, 1'b0);
        chk("t5_ready", a_ready, 1'b0);
        load_a(32'h01FF3CA5, 0);
        wait_done_a();
        chk("t5_reload_done", a_done, 1'b1);
        chk("t5_reload_err", a_err, 1'b0);
        chk("t5_reload_chain", a_chain, 32'h01FF3CA5);

        // T6: reset mid-VERIFY, then start and abort together.
        @(negedge clk);
        load_a(32'h01FF3CA5, 0);
        wait_nsh_a(LA + 8);
        chk("t6_in_verify", {a_busy, a_sen}, 2'b11);
        #2 rst_n = 1'b0;
        #1 quiet_a("t6_reset_immediate");
        @(negedge clk);
        quiet_a("t6_reset_held");
        rst_n = 1'b1;
        a_start = 1'b1; a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_abort = 1'b0;
        chk("t6_start_abort_busy", a_busy, 1'b0);
        chk("t6_start_abort_ready", a_ready, 1'b0);
        @(negedge clk);
        quiet_a("t6_still_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
